mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
// - Memory-access pipeline stage, directly downstream of the register file.
// - Consumes the register file's address (adr) and dataToMem outputs, plus the decoded load/store/dest info.
// - Runs a single-outstanding req/ack transaction on the data-memory bus.
// - Produces registered writeback controls (write, writeReg, writeData, quarter) that feed the register file write port.
// - Stalls upstream while a transaction is in flight.
// PARAMETERS
// - DATA_W   16   data width; matches register width
// - ADDR_W   16   memory address width
// - REG_W    4    destination register index width
// - TIMEOUT  255  max BUSY cycles without mem_ack before abort; legal range 1..255
// PORTS
// - clk          in   1       rising-edge clock; the only clock
// - rst_n        in   1       synchronous, active-low reset
// - valid_in     in   1       upstream instruction valid
// - is_load      in   1       instruction is a load
// - is_store     in   1       instruction is a store
// - reg_write_in in   1       non-memory instruction writes a register
// - alu_result   in   DATA_W  result of a non-memory instruction
// - address      in   ADDR_W  memory address (register file adr)
// - store_data   in   DATA_W  store data (register file dataToMem)
// - dest_reg     in   REG_W   destination register
// - quarter_in   in   2       nibble select, forwarded to writeback
// - stall        out  1       upstream must hold its outputs while high
// - mem_req      out  1       bus request
// - mem_we       out  1       1 = store, 0 = load
// - mem_addr     out  ADDR_W  bus address
// - mem_wdata    out  DATA_W  bus write data
// - mem_rdata    in   DATA_W  bus read data; valid when mem_ack = 1
// - mem_ack      in   1       bus completes the request this cycle
// - wb_write     out  1       register-write strobe; one-cycle pulse
// - wb_reg       out  REG_W   writeback register
// - wb_data      out  DATA_W  writeback data
// - wb_quarter   out  2       writeback nibble select
// - bus_err      out  1       sticky; set on timeout
// BEHAVIOUR
// - Reset (rst_n = 0 at a clock edge):
//   - state <= IDLE; timeout counter <= 0.
//   - mem_req, mem_we, wb_write, bus_err <= 0.
//   - mem_addr, mem_wdata, wb_reg, wb_data, wb_quarter <= 0.
//   - A reset mid-transaction drops mem_req at that edge; no writeback occurs.
// - Inputs are sampled only in IDLE. valid_in is ignored in BUSY, including the ack cycle.
// - IDLE, valid_in = 1 with is_load | is_store:
//   - stall = 1 combinationally.
//   - At the next edge: latch address, store_data, dest_reg, quarter_in.
//   - Also at that edge: mem_req <= 1, mem_we <= is_store & ~is_load, state <= BUSY.
//   - Load wins if both is_load and is_store are set.
// - IDLE, valid_in = 1 with neither: stall = 0. At the next edge:
//   - wb_write <= reg_write_in; wb_data <= alu_result; wb_reg <= dest_reg; wb_quarter <= quarter_in.
//   - Latency is 1 cycle.
// - IDLE, valid_in = 0: wb_write <= 0. mem_ack is ignored.
// - BUSY:
//   - mem_req, mem_we, mem_addr, mem_wdata are held stable until completion.
//   - stall = ~mem_ack; upstream advances on the ack edge.
//   - The counter increments each cycle without ack.
// - BUSY with mem_ack: at the edge, mem_req <= 0, counter <= 0, state <= IDLE.
//   - Load: wb_write <= 1, wb_data <= mem_rdata.
//   - Store: wb_write <= 0.
//   - Minimum load latency is 2 edges from capture to the wb_write pulse.
// - BUSY, counter = TIMEOUT - 1 and no ack:
//   - At the edge: mem_req <= 0, bus_err <= 1, wb_write <= 0, counter <= 0, state <= IDLE.
//   - stall = 0 in that cycle, so the faulting instruction retires without writeback.
//   - An ack arriving in that same cycle wins; it completes normally with no error.
// - bus_err is cleared only by reset.
// - Widths are exact; no arithmetic beyond the 8-bit counter, which never wraps.
// STRUCTURE
// - Package mem_stage_pkg: state enum {IDLE, BUSY}, DATA_W/ADDR_W/REG_W defaults, TIMEOUT default.
// - Sub-module mem_timeout_ctr: 8-bit counter with clr, en, and hit at TIMEOUT - 1.
// - The FSM and all registers live in the top module.
// TESTING
// - Reset: assert rst_n = 0 mid-BUSY -> next edge mem_req = 0, wb_write = 0, bus_err = 0, state = IDLE.
// - ALU passthrough: valid_in = 1, reg_write_in = 1, alu_result = 16'h1234, dest_reg = 2
//   -> next cycle wb_write = 1, wb_data = 16'h1234, wb_reg = 2; stall never asserted.
// - Load, ack after 3 BUSY cycles: address = 16'h0040, mem_rdata = 16'hBEEF
//   -> mem_req high for 3 cycles with addr stable; wb_data = 16'hBEEF pulses for one cycle; stall low on the ack cycle.
// - Store, zero-wait ack: address = 16'h0010, store_data = 16'hA5A5
//   -> mem_we = 1, mem_wdata = 16'hA5A5 for one cycle; wb_write stays 0.
// - Timeout: TIMEOUT = 4, no ack -> mem_req drops after 4 cycles; bus_err = 1 and stays 1 through later transactions.
// - Corner cases:
//   - is_load = is_store = 1 -> mem_we = 0.
//   - A stray mem_ack in IDLE -> no effect.
//   - Ack on the timeout cycle -> normal completion, bus_err = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, timeout default and FSM state type for the memory-access stage
package mem_stage_pkg;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_REG_W   = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: 8-bit busy-cycle counter; hit flags the last cycle allowed before abort
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam logic [7:0] HIT_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) count <= '0;
        else if (en)       count <= count + 8'd1;
    end

    assign hit = count == HIT_VAL;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: single-outstanding req/ack data-memory stage producing registered writeback controls
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic [1:0]        quarter_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_write,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_quarter,
    output logic              bus_err
);
    state_t state, stateNext;
    logic   memOp, busy, done, abort, ctrHit, ctrEn;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) uCtr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (~ctrEn | ctrHit),
        .en   (ctrEn),
        .hit  (ctrHit)
    );

    always_comb begin
        busy      = state == BUSY;
        memOp     = valid_in & (is_load | is_store);
        ctrEn     = busy & ~mem_ack;
        done      = busy & mem_ack;
        abort     = busy & ~mem_ack & ctrHit;
        stall     = busy ? ~mem_ack & ~ctrHit : memOp;
        stateNext = busy ? ((done | abort) ? IDLE : BUSY) : (memOp ? BUSY : IDLE);
    end

    // dest_reg/quarter_in go straight into the writeback registers at capture; wb_write stays low until a load acks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_write   <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            wb_quarter <= '0;
            bus_err    <= 1'b0;
        end else begin
            state <= stateNext;
            if (!busy) begin
                wb_write <= valid_in & ~memOp & reg_write_in;
                if (valid_in) begin
                    wb_reg     <= dest_reg;
                    wb_quarter <= quarter_in;
                end
                if (memOp) begin
                    mem_req   <= 1'b1;
                    mem_we    <= is_store & ~is_load;
                    mem_addr  <= address;
                    mem_wdata <= store_data;
                end else if (valid_in) begin
                    wb_data <= alu_result;
                end
            end else begin
                wb_write <= done & ~mem_we;
                if (done & ~mem_we) wb_data <= mem_rdata;
                if (done | abort) mem_req <= 1'b0;
                if (abort) bus_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized transaction-level check of mem_access_stage against expected outcomes
module tb_mem_access_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, is_load = 1'b0, is_store = 1'b0, reg_write_in = 1'b0;
    logic [15:0] alu_result = '0, address = '0, store_data = '0, mem_rdata = '0;
    logic [3:0]  dest_reg = '0;
    logic [1:0]  quarter_in = '0;
    logic        mem_ack = 1'b0;
    logic        stall, mem_req, mem_we, wb_write, bus_err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  wb_reg;
    logic [1:0]  wb_quarter;

    int nChecks = 0;
    int nFail = 0;
    bit errSeen = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
        .reg_write_in(reg_write_in), .alu_result(alu_result), .address(address),
        .store_data(store_data), .dest_reg(dest_reg), .quarter_in(quarter_in), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_write(wb_write), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_quarter(wb_quarter), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        valid_in     = 1'($urandom);
        is_load      = 1'($urandom);
        is_store     = 1'($urandom);
        reg_write_in = 1'($urandom);
        alu_result   = 16'($urandom);
        address      = 16'($urandom);
        store_data   = 16'($urandom);
        dest_reg     = 4'($urandom);
        quarter_in   = 2'($urandom);
    endtask

    task automatic aluOp(input bit rw, input logic [15:0] r, input logic [3:0] dr,
                         input logic [1:0] q, input bit stray);
        @(negedge clk);
        valid_in = 1'b1; is_load = 1'b0; is_store = 1'b0; reg_write_in = rw;
        alu_result = r; dest_reg = dr; quarter_in = q; mem_ack = stray;
        address = 16'($urandom); store_data = 16'($urandom);
        #1 check("alu_stall", stall, 0);
        @(negedge clk);
        check("alu_wb_write", wb_write, rw);
        check("alu_wb_data", wb_data, r);
        check("alu_wb_reg", wb_reg, dr);
        check("alu_wb_quarter", wb_quarter, q);
        check("alu_mem_req", mem_req, 0);
        check("alu_bus_err", bus_err, errSeen);
        valid_in = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic idleStray();
        @(negedge clk);
        valid_in = 1'b0; mem_ack = 1'b1; mem_rdata = 16'($urandom);
        #1 check("idle_stall", stall, 0);
        @(negedge clk);
        check("idle_wb_write", wb_write, 0);
        check("idle_mem_req", mem_req, 0);
        mem_ack = 1'b0;
    endtask

    // d = BUSY cycles before ack (ack in cycle index d); d >= TMO means the bus never answers in time
    task automatic memOp(input bit ld, input bit st, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] rd, input logic [3:0] dr, input logic [1:0] q, input int d);
        bit we  = st & ~ld;
        bit tmo = d >= TMO;
        bit wb  = ld & ~tmo;
        int n   = tmo ? TMO : d + 1;
        @(negedge clk);
        valid_in = 1'b1; is_load = ld; is_store = st; address = a; store_data = wd;
        dest_reg = dr; quarter_in = q; mem_ack = 1'b0;
        reg_write_in = 1'($urandom); alu_result = 16'($urandom);
        #1 check("cap_stall", stall, 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("busy_req", mem_req, 1);
            check("busy_we", mem_we, we);
            check("busy_addr", mem_addr, a);
            check("busy_wdata", mem_wdata, wd);
            check("busy_wb_write", wb_write, 0);
            scramble();
            mem_ack = k == d;
            mem_rdata = (k == d) ? rd : 16'($urandom);
            #1 check("busy_stall", stall, (k == d || k == TMO - 1) ? 0 : 1);
        end
        @(negedge clk);
        errSeen |= tmo;
        check("done_req", mem_req, 0);
        check("done_wb_write", wb_write, wb);
        check("done_bus_err", bus_err, errSeen);
        if (wb) begin
            check("load_wb_data", wb_data, rd);
            check("load_wb_reg", wb_reg, dr);
            check("load_wb_quarter", wb_quarter, q);
        end
        mem_ack = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("pulse_end", wb_write, 0);
        check("post_req", mem_req, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wb_write", wb_write, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_reg", wb_reg, 0);
        check("rst_wb_quarter", wb_quarter, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;

        aluOp(1'b1, 16'h1234, 4'd2, 2'd1, 1'b0);
        memOp(1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 4'd5, 2'd3, 2);
        memOp(1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0, 4'd7, 2'd0, 0);
        memOp(1'b1, 1'b1, 16'h0020, 16'h5555, 16'hCAFE, 4'd9, 2'd2, 1);
        idleStray();
        memOp(1'b1, 1'b0, 16'h0030, 16'h0, 16'h1357, 4'd3, 2'd1, TMO - 1);
        check("ack_on_timeout_no_err", bus_err, 0);
        memOp(1'b1, 1'b0, 16'h0050, 16'h0, 16'h2468, 4'd4, 2'd0, 10);
        memOp(1'b0, 1'b1, 16'h0060, 16'h7777, 16'h0, 4'd1, 2'd2, 1);
        check("err_sticky", bus_err, 1);

        for (int i = 0; i < 60; i++) begin
            int kind = int'($urandom_range(0, 4));
            if (kind == 0)      aluOp(1'($urandom), 16'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
            else if (kind == 4) idleStray();
            else memOp(kind != 2, kind != 1, 16'($urandom), 16'($urandom), 16'($urandom),
                       4'($urandom), 2'($urandom), int'($urandom_range(0, 5)));
        end

        @(negedge clk);
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; address = 16'h00F0; mem_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check("midrst_req", mem_req, 0);
        check("midrst_wb_write", wb_write, 0);
        check("midrst_bus_err", bus_err, 0);
        check("midrst_addr", mem_addr, 0);
        rst_n = 1'b1; mem_ack = 1'b0; errSeen = 1'b0;
        aluOp(1'b1, 16'h0BAD, 4'd6, 2'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
